// File: rtl/bk_pkg.sv
// Shared types and helpers for the Brent-Kung adder sequencer.
package bk_pkg;
  localparam int DEF_WIDTH = 12;
  localparam int SCNT_W    = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  // Adder bus layout: bit 2i = A[i], bit 2i+1 = B[i].
  function automatic logic [2*DEF_WIDTH-1:0] interleave(input logic [DEF_WIDTH-1:0] a,
                                                         input logic [DEF_WIDTH-1:0] b);
    logic [2*DEF_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < DEF_WIDTH; i++) begin
      r[2*i]   = a[i];
      r[2*i+1] = b[i];
    end
    return r;
  endfunction
endpackage

// File: rtl/bk_pair_fifo.sv
// Two-entry operand-pair FIFO; full/empty come straight from flops.
module bk_pair_fifo #(
  parameter int W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_push,
  input  logic [2*W-1:0] i_data,
  input  logic           i_pop,
  output logic [2*W-1:0] o_data,
  output logic           o_full,
  output logic           o_empty
);
  logic [2*W-1:0] r_mem [2];
  logic           r_wp, r_rp;
  logic [1:0]     r_cnt;
  logic           r_full, r_empty;
  logic [1:0]     w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({i_push, i_pop})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_cnt   <= 2'd0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (i_pop) r_rp <= ~r_rp;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == 2'd2);
      r_empty <= (w_cnt_nxt == 2'd0);
    end
  end

  assign o_data  = r_mem[r_rp];
  assign o_full  = r_full;
  assign o_empty = r_empty;
endmodule

// File: rtl/bk_add_sequencer.sv
// Feeds a combinational Brent-Kung adder from a held operand register, waits
// SETTLE_CYCLES so the adder can be a multicycle path, then hands off the result.
module bk_add_sequencer
  import bk_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [2*WIDTH-1:0] add_inputs,
  input  logic [WIDTH:0]     add_outs,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_sum,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);
  localparam logic [SCNT_W-1:0] SCNT_INIT = SCNT_W'(SETTLE_CYCLES);

  state_t             r_state, w_next;
  logic [SCNT_W-1:0]  r_cnt;
  logic [2*WIDTH-1:0] r_add_in;
  logic               r_out_valid;
  logic [WIDTH:0]     r_out_sum;
  logic [CNT_W-1:0]   r_op_count;

  logic               w_full, w_empty, w_push, w_pop, w_capture, w_handoff;
  logic [2*WIDTH-1:0] w_head, w_il;

  assign in_ready = !w_full && !rst;
  assign w_push   = in_valid && in_ready;

  bk_pair_fifo #(.W(WIDTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({in_a, in_b}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Package helper is fixed at the default width; other widths use a bit loop.
  if (WIDTH == DEF_WIDTH) begin : g_pkg_il
    assign w_il = interleave(w_head[2*WIDTH-1:WIDTH], w_head[WIDTH-1:0]);
  end else begin : g_loop_il
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign w_il[2*i]   = w_head[WIDTH+i];
      assign w_il[2*i+1] = w_head[i];
    end
  end

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_handoff = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == SCNT_W'(1)) begin
          w_capture = 1'b1;
          w_next    = HOLD;
        end
      end
      HOLD: begin
        if (r_out_valid && out_ready) begin
          w_handoff = 1'b1;
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = SETTLE;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_add_in    <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_op_count  <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        r_add_in <= w_il;
        r_cnt    <= SCNT_INIT;
      end else if (r_state == SETTLE) begin
        r_cnt <= r_cnt - SCNT_W'(1);
      end
      if (w_capture) begin
        r_out_sum   <= add_outs;
        r_out_valid <= 1'b1;
      end
      if (w_handoff) begin
        r_out_valid <= 1'b0;
        r_op_count  <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign add_inputs = r_add_in;
  assign out_valid  = r_out_valid;
  assign out_sum    = r_out_sum;
  assign op_count   = r_op_count;
  assign busy       = (r_state != IDLE) || !w_empty;
endmodule

// File: tb/tb_bk_add_sequencer.sv
// Directed bench: s1 instance (SETTLE=1, 4-bit counter, ideal adder) and
// s4 instance (SETTLE=4, adder output delayed by 3 cycles).
module tb_bk_add_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic        s1_rst, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready, s1_busy;
  logic [11:0] s1_in_a, s1_in_b;
  logic [23:0] s1_add_inputs;
  logic [12:0] s1_add_outs, s1_out_sum;
  logic [3:0]  s1_op_count;

  logic        s4_rst, s4_in_valid, s4_in_ready, s4_out_valid, s4_out_ready, s4_busy;
  logic [11:0] s4_in_a, s4_in_b;
  logic [23:0] s4_add_inputs;
  logic [12:0] s4_add_outs, s4_out_sum;
  logic [15:0] s4_op_count;
  logic [12:0] m4_d1 = '0, m4_d2 = '0, m4_d3 = '0;

  function automatic logic [12:0] adder(input logic [23:0] x);
    logic [11:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a[i] = x[2*i];
      b[i] = x[2*i+1];
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign s1_add_outs = adder(s1_add_inputs);
  always @(posedge clk) begin
    m4_d1 <= adder(s4_add_inputs);
    m4_d2 <= m4_d1;
    m4_d3 <= m4_d2;
  end
  assign s4_add_outs = m4_d3;

  bk_add_sequencer #(.WIDTH(12), .SETTLE_CYCLES(1), .CNT_W(4)) u_s1 (
    .clk(clk), .rst(s1_rst), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .in_a(s1_in_a), .in_b(s1_in_b), .add_inputs(s1_add_inputs), .add_outs(s1_add_outs),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_sum(s1_out_sum),
    .busy(s1_busy), .op_count(s1_op_count)
  );

  bk_add_sequencer #(.WIDTH(12), .SETTLE_CYCLES(4), .CNT_W(16)) u_s4 (
    .clk(clk), .rst(s4_rst), .in_valid(s4_in_valid), .in_ready(s4_in_ready),
    .in_a(s4_in_a), .in_b(s4_in_b), .add_inputs(s4_add_inputs), .add_outs(s4_add_outs),
    .out_valid(s4_out_valid), .out_ready(s4_out_ready), .out_sum(s4_out_sum),
    .busy(s4_busy), .op_count(s4_op_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic reset1();
    s1_rst = 1'b1;
    s1_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    s1_rst = 1'b0;
  endtask

  // Leaves the caller at the negedge where out_valid is high (or timed out).
  task automatic run1(input logic [11:0] a, input logic [11:0] b, output int lat);
    int k;
    k = 0;
    while (!s1_in_ready && k < 20) begin @(negedge clk); k++; end
    if (!s1_in_ready) chk("s1_in_ready_wait", {31'b0, s1_in_ready}, 32'd1);
    s1_in_a = a; s1_in_b = b; s1_in_valid = 1'b1;
    @(negedge clk);
    s1_in_valid = 1'b0;
    lat = 0;
    while (!s1_out_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!s1_out_valid) chk("s1_out_valid_wait", {31'b0, s1_out_valid}, 32'd1);
  endtask

  task automatic run4(input logic [11:0] a, input logic [11:0] b, input logic [23:0] il,
                      output int lat, output int bad);
    s4_in_a = a; s4_in_b = b; s4_in_valid = 1'b1;
    @(negedge clk);
    s4_in_valid = 1'b0;
    lat = 0;
    bad = 0;
    while (!s4_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (s4_add_inputs !== il) bad++;
    end
    if (!s4_out_valid) chk("s4_out_valid_wait", {31'b0, s4_out_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bad, got, seen;
    logic [12:0] bp_exp [3];
    bp_exp = '{13'h579, 13'h1000, 13'h800};

    s1_rst = 1'b1; s1_in_valid = 1'b0; s1_in_a = '0; s1_in_b = '0; s1_out_ready = 1'b1;
    s4_rst = 1'b1; s4_in_valid = 1'b0; s4_in_a = '0; s4_in_b = '0; s4_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",   {31'b0, s1_in_ready}, 0);
    chk("rst_out_valid",  {31'b0, s1_out_valid}, 0);
    chk("rst_add_inputs", {8'b0, s1_add_inputs}, 0);
    chk("rst_out_sum",    {19'b0, s1_out_sum}, 0);
    chk("rst_op_count",   {28'b0, s1_op_count}, 0);
    chk("rst_s4_add_in",  {8'b0, s4_add_inputs}, 0);
    s1_rst = 1'b0; s4_rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready",  {31'b0, s1_in_ready}, 1);

    // Single op
    run1(12'h0FF, 12'h001, lat);
    chk("t1_latency", lat, 2);
    chk("t1_add_inputs", {8'b0, s1_add_inputs}, 32'h005557);
    chk("t1_out_sum", {19'b0, s1_out_sum}, 32'h100);
    @(negedge clk);
    chk("t1_valid_clr", {31'b0, s1_out_valid}, 0);
    chk("t1_op_count", {28'b0, s1_op_count}, 1);

    // Carry-out
    run1(12'hFFF, 12'h001, lat);
    chk("carry_fff_1", {19'b0, s1_out_sum}, 32'h1000);
    @(negedge clk);
    run1(12'h800, 12'h800, lat);
    chk("carry_800_800", {19'b0, s1_out_sum}, 32'h1000);
    @(negedge clk);
    chk("carry_op_count", {28'b0, s1_op_count}, 3);

    // Backpressure: 3 back-to-back pushes with downstream stalled
    reset1();
    s1_out_ready = 1'b0;
    s1_in_a = 12'h123; s1_in_b = 12'h456; s1_in_valid = 1'b1;
    @(negedge clk);
    s1_in_a = 12'hABC; s1_in_b = 12'h544;
    @(negedge clk);
    chk("bp_ready_before_3rd", {31'b0, s1_in_ready}, 1);
    s1_in_a = 12'h7FF; s1_in_b = 12'h001;
    @(negedge clk);
    s1_in_valid = 1'b0;
    chk("bp_full_ready", {31'b0, s1_in_ready}, 0);
    chk("bp_hold_valid", {31'b0, s1_out_valid}, 1);
    chk("bp_hold_sum", {19'b0, s1_out_sum}, 32'h579);
    chk("bp_busy", {31'b0, s1_busy}, 1);
    repeat (3) @(negedge clk);
    chk("bp_sum_stable", {19'b0, s1_out_sum}, 32'h579);
    chk("bp_still_full", {31'b0, s1_in_ready}, 0);
    s1_out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 3; c++) begin
      if (s1_out_valid) begin
        chk($sformatf("bp_result%0d", got), {19'b0, s1_out_sum}, {19'b0, bp_exp[got]});
        got++;
      end
      @(negedge clk);
    end
    chk("bp_results_seen", got, 3);
    chk("bp_op_count", {28'b0, s1_op_count}, 3);

    // Reset mid-op: one pair in SETTLE, one buffered
    s1_in_a = 12'h111; s1_in_b = 12'h222; s1_in_valid = 1'b1;
    @(negedge clk);
    s1_in_a = 12'h333; s1_in_b = 12'h444;
    @(negedge clk);
    s1_in_valid = 1'b0;
    chk("mid_busy", {31'b0, s1_busy}, 1);
    s1_rst = 1'b1;
    @(negedge clk);
    chk("mid_out_valid", {31'b0, s1_out_valid}, 0);
    chk("mid_add_inputs", {8'b0, s1_add_inputs}, 0);
    chk("mid_op_count", {28'b0, s1_op_count}, 0);
    chk("mid_in_ready", {31'b0, s1_in_ready}, 0);
    chk("mid_fifo_empty", {31'b0, s1_busy}, 0);
    s1_rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (s1_out_valid) seen++;
    end
    chk("mid_no_stale", seen, 0);
    chk("mid_ready_back", {31'b0, s1_in_ready}, 1);

    // Counter wrap (4-bit counter)
    reset1();
    for (int i = 0; i < 17; i++) begin
      run1(12'(i * 3), 12'(i), lat);
      chk($sformatf("wrap_sum%0d", i), {19'b0, s1_out_sum}, i * 4);
      @(negedge clk);
      if (i == 14) chk("wrap_count15", {28'b0, s1_op_count}, 15);
    end
    chk("wrap_count", {28'b0, s1_op_count}, 1);

    // SETTLE_CYCLES=4 with a 3-cycle adder
    run4(12'h5A5, 12'h3C3, 24'h1BE41B, lat, bad);
    chk("s4_latency", lat, 5);
    chk("s4_stable", bad, 0);
    chk("s4_sum", {19'b0, s4_out_sum}, 32'h968);
    @(negedge clk);
    run4(12'hFFF, 12'hFFF, 24'hFFFFFF, lat, bad);
    chk("s4_latency2", lat, 5);
    chk("s4_stable2", bad, 0);
    chk("s4_sum2", {19'b0, s4_out_sum}, 32'h1FFE);
    @(negedge clk);
    chk("s4_op_count", {16'b0, s4_op_count}, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
